// File: rtl/controle_envase.sv
// Bottling line sequencer: fill, cork and release each bottle, count
// completed bottles and pace cork refill requests to the stock block.
module controle_envase #(
    parameter int CAP_CYCLES   = 4,
    parameter int FILL_TIMEOUT = 200,
    parameter int REFILL_GAP   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sensor_garrafa,
    input  logic       sensor_nivel,
    input  logic       sensor_vedacao,
    input  logic [7:0] rolhas_linha,
    input  logic       alerta_estoque,
    input  logic       repor,
    output logic       MOTOR,
    output logic       VALVULA,
    output logic       VEDADOR,
    output logic       DONE,
    output logic       ADD_ROLHA,
    output logic       ALARME,
    output logic [7:0] CONTAGEM_GARRAFAS,
    output logic [2:0] ESTADO
);

    localparam int TMAX = (FILL_TIMEOUT > CAP_CYCLES) ? FILL_TIMEOUT : CAP_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int GW   = $clog2(REFILL_GAP + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TRANSPORTE = 3'd1,
        ENCHENDO   = 3'd2,
        AVANCA     = 3'd3,
        SEM_ROLHA  = 3'd4,
        VEDANDO    = 3'd5,
        LIBERA     = 3'd6,
        ERRO       = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            add_req;
    logic            tem_rolha;

    assign tem_rolha = (rolhas_linha != 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = TRANSPORTE;
            end
            TRANSPORTE: begin
                if (!start)              state_d = IDLE;
                else if (sensor_garrafa) state_d = ENCHENDO;
            end
            ENCHENDO: begin
                if (sensor_nivel)
                    state_d = AVANCA;
                else if (timer_q == TW'(FILL_TIMEOUT - 1))
                    state_d = ERRO;
            end
            AVANCA: begin
                if (sensor_vedacao)
                    state_d = tem_rolha ? VEDANDO : SEM_ROLHA;
            end
            SEM_ROLHA: begin
                if (tem_rolha) state_d = VEDANDO;
            end
            VEDANDO: begin
                if (timer_q == TW'(CAP_CYCLES - 1)) state_d = LIBERA;
            end
            LIBERA: begin
                if (!sensor_vedacao)
                    state_d = start ? TRANSPORTE : IDLE;
            end
            ERRO: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared timer: fill timeout in ENCHENDO, hold time in VEDANDO.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == ENCHENDO || state_q == VEDANDO))
            timer_d = timer_q + TW'(1);
    end

    always_comb begin
        done_d = (state_q == VEDANDO) && (state_d == LIBERA);
        cnt_d  = cnt_q + {7'd0, done_d};
    end

    // Refill pacer is independent of the sequencer state.
    always_comb begin
        add_req = repor && alerta_estoque && (gap_q == '0);
        gap_d   = gap_q;
        if (add_req)
            gap_d = GW'(REFILL_GAP - 1);
        else if (gap_q != '0)
            gap_d = gap_q - GW'(1);
    end

    always_comb begin
        MOTOR   = 1'b0;
        VALVULA = 1'b0;
        VEDADOR = 1'b0;
        ALARME  = 1'b0;
        unique case (state_q)
            TRANSPORTE: MOTOR   = 1'b1;
            ENCHENDO:   VALVULA = 1'b1;
            AVANCA:     MOTOR   = 1'b1;
            SEM_ROLHA:  ALARME  = 1'b1;
            VEDANDO:    VEDADOR = 1'b1;
            LIBERA:     MOTOR   = 1'b1;
            ERRO:       ALARME  = 1'b1;
            default: ;
        endcase
    end

    assign ADD_ROLHA         = add_req && reset;
    assign DONE              = done_q;
    assign CONTAGEM_GARRAFAS = cnt_q;
    assign ESTADO            = state_q;

endmodule

// File: tb/tb_controle_envase.sv
// Directed bench for the bottling line sequencer.
module tb_controle_envase;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sensor_garrafa;
    logic       sensor_nivel;
    logic       sensor_vedacao;
    logic [7:0] rolhas_linha;
    logic       alerta_estoque;
    logic       repor;
    logic       MOTOR;
    logic       VALVULA;
    logic       VEDADOR;
    logic       DONE;
    logic       ADD_ROLHA;
    logic       ALARME;
    logic [7:0] CONTAGEM_GARRAFAS;
    logic [2:0] ESTADO;

    int checks;
    int errors;
    int done_cnt;

    controle_envase dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .sensor_garrafa    (sensor_garrafa),
        .sensor_nivel      (sensor_nivel),
        .sensor_vedacao    (sensor_vedacao),
        .rolhas_linha      (rolhas_linha),
        .alerta_estoque    (alerta_estoque),
        .repor             (repor),
        .MOTOR             (MOTOR),
        .VALVULA           (VALVULA),
        .VEDADOR           (VEDADOR),
        .DONE              (DONE),
        .ADD_ROLHA         (ADD_ROLHA),
        .ALARME            (ALARME),
        .CONTAGEM_GARRAFAS (CONTAGEM_GARRAFAS),
        .ESTADO            (ESTADO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (DONE === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        start          = 1'b0;
        sensor_garrafa = 1'b0;
        sensor_nivel   = 1'b0;
        sensor_vedacao = 1'b0;
        rolhas_linha   = 8'd0;
        alerta_estoque = 1'b0;
        repor          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repor = 1'b1;
        alerta_estoque = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ESTADO !== 3'd0) begin
            errors++;
            $display("FAIL reset_estado: got %0d want 0", ESTADO);
        end
        checks++;
        if ({MOTOR, VALVULA, VEDADOR, DONE, ALARME} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {MOTOR, VALVULA, VEDADOR, DONE, ALARME});
        end
        checks++;
        if (ADD_ROLHA !== 1'b0) begin
            errors++;
            $display("FAIL reset_add_rolha: got %b want 0", ADD_ROLHA);
        end
        checks++;
        if (CONTAGEM_GARRAFAS !== 8'd0) begin
            errors++;
            $display("FAIL reset_contagem: got %0d want 0", CONTAGEM_GARRAFAS);
        end
        do_reset();
    endtask

    task automatic test_nominal();
        int vcnt;
        int d0;
        do_reset();
        d0 = done_cnt;
        start = 1'b1;
        rolhas_linha = 8'd10;
        tick();
        checks++;
        if (ESTADO !== 3'd1 || MOTOR !== 1'b1) begin
            errors++;
            $display("FAIL nom_transporte: estado=%0d motor=%b want 1/1", ESTADO, MOTOR);
        end
        tick();
        sensor_garrafa = 1'b1;
        tick();
        checks++;
        if (ESTADO !== 3'd2 || VALVULA !== 1'b1 || MOTOR !== 1'b0) begin
            errors++;
            $display("FAIL nom_enchendo: estado=%0d valv=%b motor=%b want 2/1/0",
                     ESTADO, VALVULA, MOTOR);
        end
        sensor_garrafa = 1'b0;
        repeat (4) tick();
        sensor_nivel = 1'b1;
        tick();
        checks++;
        if (ESTADO !== 3'd3 || MOTOR !== 1'b1) begin
            errors++;
            $display("FAIL nom_avanca: estado=%0d motor=%b want 3/1", ESTADO, MOTOR);
        end
        sensor_nivel = 1'b0;
        sensor_vedacao = 1'b1;
        tick();
        vcnt = 0;
        for (int k = 0; k < 10 && ESTADO == 3'd5; k++) begin
            if (VEDADOR === 1'b1) vcnt++;
            tick();
        end
        checks++;
        if (vcnt !== 4) begin
            errors++;
            $display("FAIL nom_vedador_cycles: got %0d want 4", vcnt);
        end
        checks++;
        if (ESTADO !== 3'd6 || DONE !== 1'b1 || CONTAGEM_GARRAFAS !== 8'd1) begin
            errors++;
            $display("FAIL nom_libera: estado=%0d done=%b cnt=%0d want 6/1/1",
                     ESTADO, DONE, CONTAGEM_GARRAFAS);
        end
        sensor_vedacao = 1'b0;
        tick();
        checks++;
        if (ESTADO !== 3'd1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL nom_back_transporte: estado=%0d done=%b want 1/0", ESTADO, DONE);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL nom_done_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_fill_timeout();
        do_reset();
        start = 1'b1;
        tick();
        sensor_garrafa = 1'b1;
        tick();
        sensor_garrafa = 1'b0;
        repeat (199) tick();
        checks++;
        if (ESTADO !== 3'd2) begin
            errors++;
            $display("FAIL to_still_filling: estado=%0d want 2", ESTADO);
        end
        tick();
        checks++;
        if (ESTADO !== 3'd7 || ALARME !== 1'b1 || VALVULA !== 1'b0 || MOTOR !== 1'b0) begin
            errors++;
            $display("FAIL to_erro: estado=%0d alarme=%b valv=%b motor=%b want 7/1/0/0",
                     ESTADO, ALARME, VALVULA, MOTOR);
        end
        repeat (3) tick();
        checks++;
        if (ESTADO !== 3'd7) begin
            errors++;
            $display("FAIL to_erro_hold: estado=%0d want 7", ESTADO);
        end
        start = 1'b0;
        tick();
        checks++;
        if (ESTADO !== 3'd0 || ALARME !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: estado=%0d alarme=%b want 0/0", ESTADO, ALARME);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        start = 1'b1;
        tick();
        sensor_garrafa = 1'b1;
        tick();
        sensor_garrafa = 1'b0;
        sensor_nivel = 1'b1;
        tick();
        sensor_nivel = 1'b0;
        rolhas_linha = 8'd0;
        sensor_vedacao = 1'b1;
        tick();
        checks++;
        if (ESTADO !== 3'd4 || MOTOR !== 1'b0 || ALARME !== 1'b1) begin
            errors++;
            $display("FAIL sr_enter: estado=%0d motor=%b alarme=%b want 4/0/1",
                     ESTADO, MOTOR, ALARME);
        end
        tick();
        checks++;
        if (ESTADO !== 3'd4) begin
            errors++;
            $display("FAIL sr_hold: estado=%0d want 4", ESTADO);
        end
        rolhas_linha = 8'd15;
        tick();
        checks++;
        if (ESTADO !== 3'd5 || VEDADOR !== 1'b1 || ALARME !== 1'b0) begin
            errors++;
            $display("FAIL sr_vedando: estado=%0d vedador=%b alarme=%b want 5/1/0",
                     ESTADO, VEDADOR, ALARME);
        end
        repeat (4) tick();
        sensor_vedacao = 1'b0;
        tick();
        checks++;
        if (CONTAGEM_GARRAFAS !== 8'd1 || ESTADO !== 3'd1) begin
            errors++;
            $display("FAIL sr_complete: cnt=%0d estado=%0d want 1/1",
                     CONTAGEM_GARRAFAS, ESTADO);
        end
    endtask

    task automatic test_refill();
        int pulses;
        logic exp;
        do_reset();
        repor = 1'b1;
        alerta_estoque = 1'b1;
        #1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            exp = (i % 8 == 0);
            if (ADD_ROLHA === 1'b1) pulses++;
            checks++;
            if (ADD_ROLHA !== exp) begin
                errors++;
                $display("FAIL refill_c%0d: ADD_ROLHA=%b want %b", i, ADD_ROLHA, exp);
            end
            tick();
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL refill_pulses: got %0d want 4", pulses);
        end
        repor = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ADD_ROLHA !== 1'b0) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL refill_disabled: got %0d pulses want 0", pulses);
        end
        alerta_estoque = 1'b0;
    endtask

    task automatic test_wrap();
        int d0;
        do_reset();
        start = 1'b1;
        rolhas_linha = 8'd10;
        tick();
        d0 = done_cnt;
        for (int b = 0; b < 256; b++) begin
            sensor_garrafa = 1'b1;
            sensor_nivel = 1'b1;
            sensor_vedacao = 1'b1;
            repeat (3) tick();
            sensor_garrafa = 1'b0;
            sensor_nivel = 1'b0;
            repeat (4) tick();
            sensor_vedacao = 1'b0;
            tick();
            if (b == 254) begin
                checks++;
                if (CONTAGEM_GARRAFAS !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: cnt=%0d want 255", CONTAGEM_GARRAFAS);
                end
            end
            if (b == 255) begin
                checks++;
                if (CONTAGEM_GARRAFAS !== 8'd0 || ESTADO !== 3'd1) begin
                    errors++;
                    $display("FAIL wrap_0: cnt=%0d estado=%0d want 0/1",
                             CONTAGEM_GARRAFAS, ESTADO);
                end
            end
        end
        checks++;
        if (done_cnt - d0 !== 256) begin
            errors++;
            $display("FAIL wrap_done_pulses: got %0d want 256", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_cork();
        int d0;
        do_reset();
        start = 1'b1;
        rolhas_linha = 8'd10;
        tick();
        sensor_garrafa = 1'b1;
        tick();
        sensor_garrafa = 1'b0;
        sensor_nivel = 1'b1;
        tick();
        sensor_nivel = 1'b0;
        sensor_vedacao = 1'b1;
        tick();
        tick();
        checks++;
        if (ESTADO !== 3'd5 || VEDADOR !== 1'b1) begin
            errors++;
            $display("FAIL rc_in_vedando: estado=%0d vedador=%b want 5/1", ESTADO, VEDADOR);
        end
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({MOTOR, VALVULA, VEDADOR, DONE, ALARME, ADD_ROLHA} !== 6'b0 ||
            ESTADO !== 3'd0) begin
            errors++;
            $display("FAIL rc_async: outs=%b estado=%0d want 000000/0",
                     {MOTOR, VALVULA, VEDADOR, DONE, ALARME, ADD_ROLHA}, ESTADO);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        sensor_vedacao = 1'b0;
        tick();
        checks++;
        if (ESTADO !== 3'd0 || CONTAGEM_GARRAFAS !== 8'd0) begin
            errors++;
            $display("FAIL rc_release: estado=%0d cnt=%0d want 0/0",
                     ESTADO, CONTAGEM_GARRAFAS);
        end
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL rc_no_done: got %0d pulses want 0", done_cnt - d0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_cnt = 0;
        reset = 1'b0;
        start = 1'b0;
        sensor_garrafa = 1'b0;
        sensor_nivel = 1'b0;
        sensor_vedacao = 1'b0;
        rolhas_linha = 8'd0;
        alerta_estoque = 1'b0;
        repor = 1'b0;
        test_reset();
        test_nominal();
        test_fill_timeout();
        test_starvation();
        test_refill();
        test_wrap();
        test_reset_mid_cork();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: sim time exceeded, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
